// File: rtl/sprite_rom_pkg.sv
// Shared types and constants for the sprite ROM arbiter and its picker.
package sprite_rom_pkg;

  localparam int unsigned NREQ_DEFAULT = 4;
  localparam int unsigned REQ_ID_W     = $clog2(NREQ_DEFAULT);

  typedef logic [REQ_ID_W-1:0] req_id_t;

  localparam req_id_t REQ_PLAYER = req_id_t'(0);
  localparam req_id_t REQ_ALIEN  = req_id_t'(1);
  localparam req_id_t REQ_BULLET = req_id_t'(2);
  localparam req_id_t REQ_SHIELD = req_id_t'(3);

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
module rr_pick
  import sprite_rom_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned IDW  = $clog2(NREQ_DEFAULT)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  winner,
  output logic [NREQ-1:0] gnt
);

  always_comb begin
    int unsigned idx;
    logic [IDW-1:0] idx_b;
    idx    = 0;
    idx_b  = '0;
    any    = 1'b0;
    winner = '0;
    gnt    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx   = (int'(ptr) + k) % NREQ;
      idx_b = IDW'(idx);
      if (!any && req[idx_b]) begin
        any    = 1'b1;
        winner = idx_b;
      end
    end
    if (any) gnt[winner] = 1'b1;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM port between NREQ requesters and routes
// each read response back to its requester after the ROM latency.
module sprite_rom_arbiter
  import sprite_rom_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEFAULT,
  parameter int unsigned ADDRW   = 10,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ADDRW-1:0] req_addr,
  output logic [NREQ-1:0]       gnt,
  output logic [ADDRW-1:0]      rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [IDW-1:0]   ptr;
  logic             pick_any;
  logic [IDW-1:0]   pick_winner;
  logic [NREQ-1:0]  pick_gnt;
  logic             any_gnt;
  logic [ADDRW-1:0] win_addr;
  logic [ADDRW-1:0] addr_hold;

  logic [ROM_LAT-1:0] pipe_vld;
  logic [IDW-1:0]     pipe_id [ROM_LAT];

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (pick_any),
    .winner (pick_winner),
    .gnt    (pick_gnt)
  );

  assign any_gnt  = pick_any & ~rst;
  assign gnt      = rst ? '0 : pick_gnt;
  assign win_addr = req_addr[int'(pick_winner)*ADDRW +: ADDRW];

  // Hold the last granted address while idle so the ROM input stays quiet.
  always_comb begin
    rom_addr = addr_hold;
    if (any_gnt) rom_addr = win_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      addr_hold <= '0;
    end else if (any_gnt) begin
      ptr       <= (pick_winner == IDW'(NREQ-1)) ? '0 : pick_winner + 1'b1;
      addr_hold <= win_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= any_gnt;
      for (int unsigned k = 1; k < ROM_LAT; k++) pipe_vld[k] <= pipe_vld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_id[0] <= pick_winner;
    for (int unsigned k = 1; k < ROM_LAT; k++) pipe_id[k] <= pipe_id[k-1];
  end

  // Gating with rst also drops a response that would land in the reset cycle.
  always_comb begin
    rsp_valid = '0;
    if (pipe_vld[ROM_LAT-1] && !rst) rsp_valid[pipe_id[ROM_LAT-1]] = 1'b1;
  end

  assign rsp_data = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios plus random traffic against
// a per-cycle scoreboard, with ROM latency 1 and 3 instances driven in parallel.
module tb_sprite_rom_arbiter;
  import sprite_rom_pkg::*;

  localparam int MAXC = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [39:0] req_addr;
  logic [3:0] gnt1, gnt3, rv1, rv3;
  logic [9:0] ra1, ra3;
  logic [7:0] rd1, rd3, rq1;
  logic [7:0] rq3 [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] romf(input logic [9:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  always_ff @(posedge clk) rq1 <= romf(ra1);
  always_ff @(posedge clk) begin
    rq3[0] <= romf(ra3);
    rq3[1] <= rq3[0];
    rq3[2] <= rq3[1];
  end

  sprite_rom_arbiter #(.NREQ(4), .ADDRW(10), .WIDTH(8), .ROM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt1),
    .rom_addr(ra1), .rom_data(rq1), .rsp_valid(rv1), .rsp_data(rd1)
  );

  sprite_rom_arbiter #(.NREQ(4), .ADDRW(10), .WIDTH(8), .ROM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt3),
    .rom_addr(ra3), .rom_data(rq3[2]), .rsp_valid(rv3), .rsp_data(rd3)
  );

  // Requester-side protocol: a pending request must stay up until granted.
  logic [3:0] pr = '0, pg = '0;
  logic       prs = 1'b1;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (pr[i] && !pg[i] && !prs)
        assert (req[i] === 1'b1) else begin
          errors++;
          $error("FAIL req_drop[%0d] observed=%b expected=1", i, req[i]);
        end
    pr  = req;
    pg  = gnt1;
    prs = rst;
  end

  // Scoreboard state
  int         m_ptr = 0;
  logic [9:0] m_hold = '0;
  bit         pend [4];
  logic [9:0] paddr [4];
  bit         cont = 0;
  int         cyc = 0;
  bit         ev  [2][MAXC];
  int         eid [2][MAXC];
  logic [7:0] ed  [2][MAXC];
  logic [3:0] obs_gnt, obs_rv1, obs_rv3;
  logic [9:0] obs_addr;
  logic [7:0] obs_rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic post(input int i, input logic [9:0] a);
    pend[i]  = 1;
    paddr[i] = a;
  endtask

  task automatic step();
    int w;
    logic [3:0] eg;
    logic [9:0] ea;
    logic [3:0] erv [2];
    for (int i = 0; i < 4; i++) begin
      req[i] = pend[i];
      req_addr[i*10 +: 10] = paddr[i];
    end
    @(negedge clk);
    w = -1;
    if (!rst)
      for (int k = 0; k < 4; k++)
        if (w < 0 && pend[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    ea = (w >= 0) ? paddr[w] : m_hold;
    if (rst)
      for (int c = cyc; c < MAXC; c++) begin
        ev[0][c] = 0;
        ev[1][c] = 0;
      end
    for (int l = 0; l < 2; l++) erv[l] = ev[l][cyc] ? (4'b1 << eid[l][cyc]) : 4'b0;
    chk("gnt_lat1", gnt1, eg);
    chk("gnt_lat3", gnt3, eg);
    chk("rom_addr_lat1", ra1, ea);
    chk("rom_addr_lat3", ra3, ea);
    chk("rsp_valid_lat1", rv1, erv[0]);
    chk("rsp_valid_lat3", rv3, erv[1]);
    if (ev[0][cyc]) chk("rsp_data_lat1", rd1, ed[0][cyc]);
    if (ev[1][cyc]) chk("rsp_data_lat3", rd3, ed[1][cyc]);
    obs_gnt = gnt1; obs_addr = ra1; obs_rv1 = rv1; obs_rd1 = rd1; obs_rv3 = rv3;
    if (w >= 0 && cyc + 3 < MAXC) begin
      ev[0][cyc+1] = 1; eid[0][cyc+1] = w; ed[0][cyc+1] = romf(paddr[w]);
      ev[1][cyc+3] = 1; eid[1][cyc+3] = w; ed[1][cyc+3] = romf(paddr[w]);
    end
    @(posedge clk);
    if (rst) begin
      m_ptr  = 0;
      m_hold = '0;
    end else if (w >= 0) begin
      m_ptr   = (w + 1) % 4;
      m_hold  = paddr[w];
      pend[w] = cont;
    end
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n;
    cont = 0;
    n = 0;
    while ((pend[0] | pend[1] | pend[2] | pend[3]) && n < 12) begin
      step();
      n++;
    end
    chk("drain_bound", {28'b0, pend[3], pend[2], pend[1], pend[0]}, 32'd0);
  endtask

  logic [7:0] seq [4];

  initial begin
    seq = '{8'h5A, 8'h5B, 8'h58, 8'h59};
    for (int i = 0; i < 4; i++) begin
      pend[i]  = 0;
      paddr[i] = '0;
    end
    req = '0;
    req_addr = '0;

    // Reset with every requester asserted
    rst = 1'b1;
    for (int i = 0; i < 4; i++) post(i, 10'(i));
    cont = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("reset_gnt", obs_gnt, 4'b0);
      chk("reset_rsp_valid", obs_rv1, 4'b0);
      chk("reset_rom_addr", obs_addr, 10'h000);
    end
    rst = 1'b0;

    // Continuous four-way contention
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_order", obs_gnt, 4'b1 << (k % 4));
      if (k > 0) begin
        chk("rr_rsp_valid", obs_rv1, 4'b1 << ((k - 1) % 4));
        chk("rr_rsp_data", obs_rd1, seq[(k - 1) % 4]);
      end
    end
    drain();
    step();
    step();

    // Single request
    post(REQ_BULLET, 10'h013);
    step();
    chk("single_gnt", obs_gnt, 4'b0100);
    step();
    chk("single_rsp_valid", obs_rv1, 4'b0100);
    chk("single_rsp_data", obs_rd1, 8'h49);

    // Contention starting from ptr=2
    post(REQ_ALIEN, 10'h100);
    step();
    chk("ptr_setup_gnt", obs_gnt, 4'b0010);
    post(REQ_PLAYER, 10'h0A0);
    post(REQ_ALIEN, 10'h0A1);
    post(REQ_SHIELD, 10'h0A3);
    step();
    chk("contend_gnt_a", obs_gnt, 4'b1000);
    step();
    chk("contend_gnt_b", obs_gnt, 4'b0001);
    step();
    chk("contend_gnt_c", obs_gnt, 4'b0010);
    step();

    // Idle hold of the last address
    post(REQ_PLAYER, 10'h2A5);
    step();
    chk("hold_grant_addr", obs_addr, 10'h2A5);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_rom_addr", obs_addr, 10'h2A5);
      chk("hold_rsp_valid", obs_rv1, (k == 0) ? 4'b0001 : 4'b0000);
    end

    // Reset one cycle after a grant drops the in-flight read
    post(REQ_ALIEN, 10'h0C3);
    step();
    chk("midrst_gnt", obs_gnt, 4'b0010);
    rst = 1'b1;
    step();
    chk("midrst_rsp_valid_lat1", obs_rv1, 4'b0);
    chk("midrst_rom_addr", obs_addr, 10'h0C3);
    step();
    chk("midrst_rom_addr_cleared", obs_addr, 10'h000);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("midrst_rsp_valid_lat3", obs_rv3, 4'b0);
    end

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(1, 0) == 1) post(i, 10'($urandom_range(1023, 0)));
      rst = ($urandom_range(59, 0) == 0);
      step();
    end
    rst = 1'b0;
    drain();
    for (int k = 0; k < 4; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Round-robin scheduler that shares one synchronous sprite ROM read port between several pixel-fetch requesters (player, aliens, bullets, shields). Each cycle it grants at most one request, drives the winner's address to the ROM, and tracks the in-flight read through the ROM's fixed read latency. It then returns the data to the original requester with a one-hot valid. It sits between the sprite renderers and the single ROM instance in the graphics pipeline.

## Interface
- NREQ, 4: number of requesters, 2..8
- ADDRW, 10: ROM address width
- WIDTH, 8: ROM data width
- ROM_LAT, 1: ROM read latency in cycles, 1..3; must match the attached ROM

- clk  in  1: single clock; all logic on posedge
- rst  in  1: reset, synchronous and active-high
- req  in  NREQ: per-requester read request
- req_addr  in  NREQ x ADDRW: per-requester address
- gnt  out  NREQ: one-hot grant, combinational, same cycle as the accepted req
- rom_addr  out  ADDRW: address to the ROM port
- rom_data  in  WIDTH: ROM output, valid ROM_LAT cycles after the address is sampled
- rsp_valid  out  NREQ: one-hot, marks the requester whose data is on rsp_data
- rsp_data  out  WIDTH: shared response bus, equal to rom_data

## Operation
- Requester rules: assert req with a stable req_addr, and hold both until gnt is seen in the same cycle. A request is accepted iff req[i] && gnt[i] at a posedge. Dropping req before gnt is illegal and is flagged by a bench assertion.
- Arbitration is round-robin using a priority pointer ptr of $clog2(NREQ) bits, reset value 0.
- The winner is the first i with req[i] set, searching ptr, ptr+1, ... with wrap mod NREQ.
- On a grant to i, ptr becomes (i+1) mod NREQ. With no grant, ptr holds.
- While rst=1, gnt is forced to 0.
- rom_addr equals req_addr[winner] when any grant is active. Otherwise it holds the last granted address in a register (reset 0), so the ROM input does not toggle while idle.
- In-flight tracking uses a ROM_LAT-deep shift register of {valid, id}. Stage 0 loads {any_gnt, winner}. rsp_valid = onehot(last stage id) when the last stage is valid, else 0.
- rsp_data = rom_data directly, with no extra register. Its value is don't-care when rsp_valid=0.
- Reset: the pipeline is cleared and ptr and the address hold register go to 0. In-flight reads are dropped and never reported.

## Timing
- Request accepted at edge t: rsp_valid[i]=1 on the cycle after edge t+ROM_LAT-1, i.e. exactly ROM_LAT cycles after the grant cycle.
- Throughput is one grant per cycle. Back-to-back grants give back-to-back responses in grant order.
- Reset outputs: gnt=0, rsp_valid=0, rom_addr=0. rsp_valid is 0 for ROM_LAT cycles after rst deasserts.
- Simultaneous requests: exactly one gnt bit, chosen by ptr. A requester is granted at most once per NREQ consecutive grants while all others request.
- Single requester: granted every cycle, and ptr still advances past it.
- Reset mid-stream: if rst is asserted in cycle t, there is no rsp_valid from cycle t+1 on, even for grants made before t.

## Structure
- Package sprite_rom_pkg holds:
  - NREQ_DEFAULT
  - typedef req_id_t (logic [$clog2(NREQ)-1:0])
  - requester index constants REQ_PLAYER=0, REQ_ALIEN=1, REQ_BULLET=2, REQ_SHIELD=3
- Sub-module rr_pick: a combinational round-robin picker with inputs req and ptr, and outputs any, winner id and one-hot gnt. It is reused by other shared-resource arbiters in the design.
- The ROM itself stays outside. The top level wires rom_addr and rom_data to a rom_sync instance.

## Test plan
All scenarios use a ROM model with contents mem[a] = a[7:0] ^ 8'h5A and ROM_LAT=1 unless noted.
- Reset: hold rst 3 cycles with all req=1 -> gnt=0, rsp_valid=0 and rom_addr=0 throughout. First grant after release goes to requester 0.
- Single request: req[2]=1, addr=0x013 for one accepted cycle -> gnt=4'b0100 that cycle. Next cycle rsp_valid=4'b0100 and rsp_data=0x49.
- All four requesting continuously with addrs 0x000/0x001/0x002/0x003 -> grants in order 0,1,2,3,0,...; rsp_data sequence 0x5A,0x5B,0x58,0x59 with matching rsp_valid, one per cycle.
- Contention after ptr=2: req=4'b1011 -> grant 3, then 0, then 1. Requester 2 is never granted while idle.
- Reset mid-stream: grant to 1 at cycle t, rst=1 at cycle t+1 -> rsp_valid stays 0 at t+1. ROM_LAT=3 variant: rst one cycle after a grant suppresses that response.
- Idle hold: grant addr 0x2A5, then no requests for 5 cycles -> rom_addr stays 0x2A5, rsp_valid=0 after the single response.
